omp_detect_ctrl: RTL and testbench

- Sequencing controller for the combinational correlation-peak detector (24 × 16-bit signed lanes in, 6-bit peak position out).
- Loads one correlation vector serially and presents it to the detector.
- Reads back the peak index, excludes that lane, and repeats for K iterations.
- Emits the ordered support set (one index per iteration) to the downstream least-squares stage through a valid/ready handshake.

---
 rtl/omp_pkg.sv | 23 ++
 rtl/omp_lane_bank.sv | 59 +++++
 rtl/omp_detect_ctrl.sv | 138 +++++++++++++
 tb/tb_omp_detect_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/omp_pkg.sv
// Shared constants, controller states and lane packing for the OMP detect path.
// The detector and the least-squares stage use the same lane-0-at-MSB packing.
package omp_pkg;

   localparam int unsigned N     = 24;
   localparam int unsigned W     = 16;
   localparam int unsigned IW    = 6;
   localparam int unsigned K_MAX = 8;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StSettle,
      StEmit,
      StFin
   } omp_state_e;

   // Lane 0 occupies the most significant W bits of the packed vector.
   function automatic int unsigned lane_lsb(input int unsigned lane);
      return N * W - W * (lane + 1);
   endfunction

endpackage

// File: rtl/omp_lane_bank.sv
// N x W correlation register file with a serial write port and a lane mask.
// Masked lanes read as zero on the packed detector vector.
module omp_lane_bank
   import omp_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            clear_i,
   input  logic            wr_en_i,
   input  logic [IW-1:0]   wr_lane_i,
   input  logic [W-1:0]    wr_data_i,
   input  logic            mask_set_i,
   input  logic [IW-1:0]   mask_lane_i,
   output logic [N-1:0]    mask_o,
   output logic [N*W-1:0]  det_x_o
);

   logic [N-1:0][W-1:0] lane_q, lane_d;
   logic [N-1:0]        mask_q, mask_d;

   // Out-of-range lane numbers match no entry and leave the bank untouched.
   always_comb begin
      lane_d = lane_q;
      mask_d = mask_q;
      if (clear_i) begin
         mask_d = '0;
      end
      for (int unsigned i = 0; i < N; i++) begin
         if (wr_en_i && (wr_lane_i == IW'(i))) begin
            lane_d[i] = wr_data_i;
         end
         if (mask_set_i && (mask_lane_i == IW'(i))) begin
            mask_d[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lane_q <= '0;
         mask_q <= '0;
      end else begin
         lane_q <= lane_d;
         mask_q <= mask_d;
      end
   end

   always_comb begin
      det_x_o = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (!mask_q[i]) begin
            det_x_o[lane_lsb(i) +: W] = lane_q[i];
         end
      end
   end

   assign mask_o = mask_q;

endmodule

// File: rtl/omp_detect_ctrl.sv
// Sequencing controller around the combinational correlation-peak detector:
// loads a vector, picks K peaks one at a time, streams the support set out.
module omp_detect_ctrl
   import omp_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [IW-1:0]   k_cfg,
   input  logic            s_valid,
   output logic            s_ready,
   input  logic [W-1:0]    s_data,
   output logic [N*W-1:0]  det_x,
   input  logic [IW-1:0]   det_pos,
   output logic            m_valid,
   input  logic            m_ready,
   output logic [IW-1:0]   m_idx,
   output logic [IW-1:0]   m_iter,
   output logic            done,
   output logic            err
);

   omp_state_e    state_q, state_d;
   logic [IW-1:0] cnt_q, cnt_d;
   logic [IW-1:0] iter_q, iter_d;
   logic [IW-1:0] k_eff_q, k_eff_d;
   logic [IW-1:0] pos_q, pos_d;
   logic          err_q, err_d;

   logic          bank_clear;
   logic          bank_wr;
   logic          mask_set;
   logic [N-1:0]  mask;
   logic          det_masked;

   omp_lane_bank u_bank (
      .clk         (clk),
      .rst_n       (rst_n),
      .clear_i     (bank_clear),
      .wr_en_i     (bank_wr),
      .wr_lane_i   (cnt_q),
      .wr_data_i   (s_data),
      .mask_set_i  (mask_set),
      .mask_lane_i (pos_q),
      .mask_o      (mask),
      .det_x_o     (det_x)
   );

   always_comb begin
      det_masked = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         if (det_pos == IW'(i)) begin
            det_masked = mask[i];
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      iter_d     = iter_q;
      k_eff_d    = k_eff_q;
      pos_d      = pos_q;
      err_d      = err_q;
      bank_clear = 1'b0;
      bank_wr    = 1'b0;
      mask_set   = 1'b0;
      s_ready    = 1'b0;
      m_valid    = 1'b0;
      done       = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               k_eff_d    = (k_cfg > IW'(K_MAX)) ? IW'(K_MAX) : k_cfg;
               cnt_d      = '0;
               iter_d     = '0;
               err_d      = 1'b0;
               bank_clear = 1'b1;
               state_d    = StLoad;
            end
         end
         StLoad: begin
            s_ready = 1'b1;
            if (s_valid) begin
               bank_wr = 1'b1;
               cnt_d   = cnt_q + IW'(1);
               if (cnt_q == IW'(N - 1)) begin
                  state_d = (k_eff_q == '0) ? StFin : StSettle;
               end
            end
         end
         StSettle: begin
            pos_d = det_pos;
            // A bad index is still emitted; only the error flag records it.
            if ((det_pos >= IW'(N)) || det_masked) begin
               err_d = 1'b1;
            end
            state_d = StEmit;
         end
         StEmit: begin
            m_valid = 1'b1;
            if (m_ready) begin
               mask_set = 1'b1;
               iter_d   = iter_q + IW'(1);
               state_d  = (iter_q + IW'(1) == k_eff_q) ? StFin : StSettle;
            end
         end
         StFin: begin
            done    = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         iter_q  <= '0;
         k_eff_q <= '0;
         pos_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         iter_q  <= iter_d;
         k_eff_q <= k_eff_d;
         pos_q   <= pos_d;
         err_q   <= err_d;
      end
   end

   assign m_idx  = pos_q;
   assign m_iter = iter_q;
   assign err    = err_q;

endmodule

// File: tb/tb_omp_detect_ctrl.sv
// Directed and randomized bench for omp_detect_ctrl with an argmax-|x| detector
// and an array-level model of the greedy support selection.
module tb_omp_detect_ctrl;
   import omp_pkg::*;

   typedef logic [15:0] vec_t [24];

   logic           clk;
   logic           rst_n;
   logic           start;
   logic [5:0]     k_cfg;
   logic           s_valid;
   logic           s_ready;
   logic [15:0]    s_data;
   logic [383:0]   det_x;
   logic [5:0]     det_pos;
   logic           m_valid;
   logic           m_ready;
   logic [5:0]     m_idx;
   logic [5:0]     m_iter;
   logic           done;
   logic           err;

   int             vectors;
   int             miscompares;
   int             exp_q [$];
   bit             exp_err_q [$];
   int             force_val [8];
   int             det_view [24];
   vec_t           base_vec;
   vec_t           rnd_vec;

   omp_detect_ctrl dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .k_cfg   (k_cfg),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .s_data  (s_data),
      .det_x   (det_x),
      .det_pos (det_pos),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_idx   (m_idx),
      .m_iter  (m_iter),
      .done    (done),
      .err     (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int mag(input int v);
      return (v < 0) ? -v : v;
   endfunction

   // Largest magnitude wins; ties go to the lowest lane.
   function automatic int peak_of(input int v [24]);
      int best = 0;
      for (int i = 1; i < 24; i++) begin
         if (mag(v[i]) > mag(v[best])) best = i;
      end
      return best;
   endfunction

   // Detector: argmax |x| unless the bench forces an index for this iteration.
   always_comb begin
      for (int i = 0; i < 24; i++) begin
         det_view[i] = int'($signed(det_x[383 - 16 * i -: 16]));
      end
      det_pos = 6'(peak_of(det_view));
      if ((m_iter < 6'd8) && (force_val[m_iter[2:0]] >= 0)) begin
         det_pos = 6'(force_val[m_iter[2:0]]);
      end
   end

   task automatic check(input string tag, input logic [383:0] obs, input logic [383:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Greedy selection with exclusion, straight from the selection rules.
   task automatic build_expect(input vec_t d, input int k);
      bit excl [24];
      int view [24];
      int keff;
      int p;
      bit e;
      keff = (k > 8) ? 8 : k;
      exp_q.delete();
      exp_err_q.delete();
      e = 1'b0;
      for (int i = 0; i < 24; i++) excl[i] = 1'b0;
      for (int it = 0; it < keff; it++) begin
         for (int i = 0; i < 24; i++) view[i] = excl[i] ? 0 : int'($signed(d[i]));
         p = (force_val[it] >= 0) ? force_val[it] : peak_of(view);
         if (p >= 24) e = 1'b1;
         else if (excl[p]) e = 1'b1;
         exp_q.push_back(p);
         exp_err_q.push_back(e);
         if (p < 24) excl[p] = 1'b1;
      end
   endtask

   task automatic load_vec(input vec_t d, input int k, input bit gaps);
      int            lane;
      int            cyc;
      logic          rdy;
      logic [383:0]  packed_x;
      start = 1'b1;
      k_cfg = 6'(k);
      tick();
      start = 1'b0;
      check("err cleared on start", err, 0);
      check("m_valid low in load", m_valid, 0);
      lane = 0;
      cyc  = 0;
      while ((lane < 24) && (cyc < 200)) begin
         rdy = s_ready;
         check($sformatf("s_ready cycle %0d", cyc), rdy, 1);
         s_valid = gaps ? (cyc % 2 == 0) : 1'b1;
         s_data  = d[lane];
         tick();
         if (s_valid && rdy) lane++;
         cyc++;
      end
      s_valid = 1'b0;
      check("samples accepted", lane, 24);
      for (int i = 0; i < 24; i++) packed_x[383 - 16 * i -: 16] = d[i];
      check("det_x after load", det_x, packed_x);
      if (k == 0) begin
         check("done after load k=0", done, 1);
         check("m_valid k=0", m_valid, 0);
         tick();
         check("done one cycle k=0", done, 0);
         check("m_valid after k=0", m_valid, 0);
      end
   endtask

   task automatic collect(input int stall, input int abort_at);
      int            waited;
      logic [383:0]  snap;
      for (int it = 0; it < exp_q.size(); it++) begin
         waited = 0;
         while (!m_valid && (waited < 8)) begin
            tick();
            waited++;
         end
         check($sformatf("m_valid latency it%0d", it), waited, 1);
         if (!m_valid) begin
            check($sformatf("m_valid wait it%0d", it), m_valid, 1);
            return;
         end
         check($sformatf("m_idx it%0d", it), m_idx, exp_q[it]);
         check($sformatf("m_iter it%0d", it), m_iter, it);
         check($sformatf("err it%0d", it), err, exp_err_q[it]);
         if (it == abort_at) begin
            rst_n = 1'b0;
            #2;
            check("reset m_valid", m_valid, 0);
            check("reset m_idx", m_idx, 0);
            check("reset m_iter", m_iter, 0);
            check("reset s_ready", s_ready, 0);
            check("reset done", done, 0);
            check("reset err", err, 0);
            check("reset det_x", det_x, 0);
            rst_n = 1'b1;
            tick();
            check("no output after reset", m_valid, 0);
            return;
         end
         if ((it == 0) && (stall > 0)) begin
            snap    = det_x;
            m_ready = 1'b0;
            for (int s = 0; s < stall; s++) begin
               tick();
               check($sformatf("stall m_valid %0d", s), m_valid, 1);
               check($sformatf("stall m_idx %0d", s), m_idx, exp_q[0]);
               check($sformatf("stall m_iter %0d", s), m_iter, 0);
               check($sformatf("stall det_x %0d", s), det_x, snap);
            end
            m_ready = 1'b1;
         end
         tick();
      end
      if (exp_q.size() > 0) begin
         check("done pulse", done, 1);
         check("m_valid in fin", m_valid, 0);
         tick();
         check("done cleared", done, 0);
         check("err sticky after run", err, exp_err_q[exp_q.size() - 1]);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed running expected finished");
      $fatal(1);
   end

   initial begin
      int k;
      int stall;
      bit gaps;
      vectors     = 0;
      miscompares = 0;
      start       = 1'b0;
      k_cfg       = '0;
      s_valid     = 1'b0;
      s_data      = '0;
      m_ready     = 1'b1;
      for (int i = 0; i < 8; i++) force_val[i] = -1;
      base_vec = '{16'hff77, 16'h0078, 16'h002d, 16'hfffc, 16'h0017, 16'hff38,
                   16'hfff5, 16'h00cd, 16'h000d, 16'h0005, 16'hffa2, 16'hfffc,
                   16'h001e, 16'h0037, 16'hffd0, 16'hffe2, 16'h0103, 16'hfedf,
                   16'h011d, 16'h002b, 16'h0080, 16'hff2b, 16'hffb4, 16'hffdc};

      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      check("por s_ready", s_ready, 0);
      check("por m_valid", m_valid, 0);
      check("por done", done, 0);
      check("por err", err, 0);
      check("por m_idx", m_idx, 0);
      check("por m_iter", m_iter, 0);
      check("por det_x", det_x, 0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // Reference sequence written out by hand.
      exp_q     = '{17, 18, 16, 21, 7, 5};
      exp_err_q = '{0, 0, 0, 0, 0, 0};
      load_vec(base_vec, 6, 1'b0);
      collect(0, -1);

      build_expect(base_vec, 6);
      load_vec(base_vec, 6, 1'b0);
      collect(5, -1);

      build_expect(base_vec, 0);
      load_vec(base_vec, 0, 1'b0);
      collect(0, -1);

      build_expect(base_vec, 40);
      check("k=40 clamps to 8 in model", exp_q.size(), 8);
      load_vec(base_vec, 40, 1'b0);
      collect(0, -1);

      build_expect(base_vec, 6);
      load_vec(base_vec, 6, 1'b1);
      collect(0, -1);

      build_expect(base_vec, 6);
      load_vec(base_vec, 6, 1'b0);
      collect(0, 3);
      build_expect(base_vec, 6);
      load_vec(base_vec, 6, 1'b0);
      collect(0, -1);

      // Out-of-range index: emitted anyway, err sticky.
      force_val[0] = 30;
      build_expect(base_vec, 3);
      load_vec(base_vec, 3, 1'b0);
      collect(0, -1);
      force_val[0] = -1;
      tick();
      check("err still sticky in idle", err, 1);

      // Repeated index hits an already-masked lane.
      force_val[1] = 17;
      build_expect(base_vec, 3);
      load_vec(base_vec, 3, 1'b0);
      collect(0, -1);
      force_val[1] = -1;

      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < 24; i++) rnd_vec[i] = 16'($urandom);
         k     = int'($urandom_range(0, 12));
         gaps  = 1'($urandom_range(0, 1));
         stall = int'($urandom_range(0, 3));
         build_expect(rnd_vec, k);
         load_vec(rnd_vec, k, gaps);
         collect(stall, -1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
